ex_mem_skid: RTL and testbench
==============================

EX_MEM_SKID -- requirements
Module: ex_mem_skid

Interface
REQ-001 No parameters; all widths fixed.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 ex_valid_i  input  1  EX stage presents a result this cycle.
REQ-005 ex_ready_o  output  1  buffer can accept an EX result this cycle.
REQ-006 write_addr_i  input  5  destination register from EX.
REQ-007 write_data_i  input  32  result data from EX.
REQ-008 write_reg_i  input  1  register write enable from EX.
REQ-009 overexcept_i  input  1  arithmetic overflow exception flag from EX.
REQ-010 flush_i  input  1  discard all buffered entries.
REQ-011 mem_valid_o  output  1  entry presented to MEM stage.
REQ-012 mem_ready_i  input  1  MEM stage accepts the presented entry.
REQ-013 write_addr_o  output  5  head entry destination register.
REQ-014 write_data_o  output  32  head entry data.
REQ-015 write_reg_o  output  1  head entry write enable, sanitised.
REQ-016 overexcept_o  output  1  head entry overflow exception flag.
REQ-017 fwd_valid_o / fwd_addr_o(5) / fwd_data_o(32)  output  bypass of youngest pending write (present only with macro, REQ-035).

Function
REQ-018 Accept = ex_valid_i & ex_ready_o; release = mem_valid_o & mem_ready_i.
REQ-019 Two storage slots: main (head, drives MEM outputs) and skid (overflow); state machine EMPTY (none), HALF (main only), FULL (main+skid).
REQ-020 ex_ready_o SHALL be a registered signal equal to 1 in EMPTY and HALF, 0 in FULL; no combinational path from mem_ready_i to ex_ready_o.
REQ-021 EMPTY: accept -> HALF, main <= input; otherwise stay.
REQ-022 HALF: accept & release -> HALF, main <= input; accept & !release -> FULL, skid <= input; !accept & release -> EMPTY; neither -> hold.
REQ-023 FULL: release -> HALF, main <= skid; otherwise hold; no accept possible.
REQ-024 mem_valid_o SHALL be 1 exactly in HALF and FULL.
REQ-025 Latency: accepted input appears on MEM outputs the next cycle when buffer was EMPTY, or HALF with simultaneous release.
REQ-026 Head outputs SHALL remain stable while mem_valid_o=1 and mem_ready_i=0.
REQ-027 Ordering strictly FIFO; no entry dropped or duplicated except by flush.
REQ-028 write_reg_o SHALL be 0 when stored overexcept=1 or stored write_addr=0, else stored write_reg.
REQ-029 flush_i has priority over accept and release: next state EMPTY, both slots invalidated, ex_ready_o=1 next cycle; an input offered in the flush cycle is discarded.
REQ-030 With mem_valid_o=0, write_addr_o, write_data_o, write_reg_o, overexcept_o SHALL be 0.

Reset
REQ-031 resetn=0 SHALL immediately force state EMPTY, ex_ready_o=0 while asserted, all other outputs 0.
REQ-032 First cycle after resetn deasserts: ex_ready_o=1, mem_valid_o=0.
REQ-033 Reset mid-transfer discards all buffered entries; no partial entry emitted.

Configuration
REQ-034 Macro EX_MEM_FORWARD_EN selects the bypass feature.
REQ-035 Defined: fwd_* ports exist; fwd_valid_o=1 when youngest valid slot (skid if FULL, else main) has sanitised write_reg=1; fwd_addr_o/fwd_data_o from that slot, all 0 otherwise.
REQ-036 Undefined: fwd_* ports absent; all other behaviour identical.

Verification
REQ-037 Reset release, ex_valid_i=1, addr=5, data=32'h1234_5678, write_reg=1, mem_ready_i=1 -> next cycle mem_valid_o=1, write_addr_o=5, write_data_o=32'h1234_5678, write_reg_o=1.
REQ-038 mem_ready_i=0, two accepts (data A=32'hA, B=32'hB) -> FULL, ex_ready_o=0, head=A stable; raise mem_ready_i -> A then B on successive cycles, then mem_valid_o=0.
REQ-039 Input overexcept=1, write_reg=1, addr=3 -> write_reg_o=0, overexcept_o=1; input addr=0, write_reg=1 -> write_reg_o=0.
REQ-040 FULL state, flush_i=1 with ex_valid_i=1 and mem_ready_i=1 -> next cycle mem_valid_o=0, ex_ready_o=1, flushed-cycle input never appears.
REQ-041 Continuous ex_valid_i=1, mem_ready_i=1 for 100 cycles with incrementing data -> one output per cycle, in order, state never FULL.
REQ-042 With EX_MEM_FORWARD_EN, FULL with main addr=4, skid addr=7 data=32'h77 -> fwd_valid_o=1, fwd_addr_o=7, fwd_data_o=32'h77.

Source files
------------

// File: rtl/ex_mem_skid.sv
// EX->MEM two-slot skid buffer with registered ready and flush.
// Define EX_MEM_FORWARD_EN to add the fwd_* bypass of the youngest pending write.
`timescale 1ns/1ps
module ex_mem_skid (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ex_valid_i,
    output logic        ex_ready_o,
    input  logic [4:0]  write_addr_i,
    input  logic [31:0] write_data_i,
    input  logic        write_reg_i,
    input  logic        overexcept_i,
    input  logic        flush_i,
    output logic        mem_valid_o,
    input  logic        mem_ready_i,
    output logic [4:0]  write_addr_o,
    output logic [31:0] write_data_o,
    output logic        write_reg_o,
    output logic        overexcept_o
`ifdef EX_MEM_FORWARD_EN
   ,output logic        fwd_valid_o,
    output logic [4:0]  fwd_addr_o,
    output logic [31:0] fwd_data_o
`endif
);
    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] HALF  = 2'b01;
    localparam logic [1:0] FULL  = 2'b10;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        wreg;
        logic        oe;
    } ent_t;

    logic [1:0] r_state;
    logic       r_rdy;
    ent_t       r_main;
    ent_t       r_skid;

    logic [1:0] w_nstate;
    logic       w_acc;
    logic       w_rel;
    logic       w_ld_main;
    logic       w_ld_skid;
    logic       w_shift;
    logic       w_vld;
    ent_t       w_in;

    assign w_in  = '{addr: write_addr_i, data: write_data_i, wreg: write_reg_i, oe: overexcept_i};
    assign w_vld = (r_state != EMPTY);
    assign w_acc = ex_valid_i & r_rdy;
    assign w_rel = w_vld & mem_ready_i;

    always_comb begin
        w_nstate  = r_state;
        w_ld_main = 1'b0;
        w_ld_skid = 1'b0;
        w_shift   = 1'b0;
        if (flush_i) begin
            w_nstate = EMPTY;
        end else begin
            case (r_state)
                EMPTY: if (w_acc) begin
                    w_nstate  = HALF;
                    w_ld_main = 1'b1;
                end
                HALF: begin
                    if (w_acc && w_rel) begin
                        w_ld_main = 1'b1;
                    end else if (w_acc) begin
                        w_nstate  = FULL;
                        w_ld_skid = 1'b1;
                    end else if (w_rel) begin
                        w_nstate  = EMPTY;
                    end
                end
                FULL: if (w_rel) begin
                    w_nstate = HALF;
                    w_shift  = 1'b1;
                end
                default: w_nstate = EMPTY;
            endcase
        end
    end

    // Ready is a pure function of the next state, so mem_ready_i never reaches ex_ready_o combinationally.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= EMPTY;
            r_rdy   <= 1'b0;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            r_state <= w_nstate;
            r_rdy   <= (w_nstate != FULL);
            if (w_ld_main)    r_main <= w_in;
            else if (w_shift) r_main <= r_skid;
            if (w_ld_skid)    r_skid <= w_in;
        end
    end

    function automatic logic san_wreg(input ent_t e);
        return e.wreg & ~e.oe & (e.addr != 5'd0);
    endfunction

    assign ex_ready_o   = r_rdy;
    assign mem_valid_o  = w_vld;
    assign write_addr_o = w_vld ? r_main.addr : 5'd0;
    assign write_data_o = w_vld ? r_main.data : 32'd0;
    assign write_reg_o  = w_vld & san_wreg(r_main);
    assign overexcept_o = w_vld & r_main.oe;

`ifdef EX_MEM_FORWARD_EN
    ent_t w_young;
    assign w_young     = (r_state == FULL) ? r_skid : r_main;
    assign fwd_valid_o = w_vld & san_wreg(w_young);
    assign fwd_addr_o  = fwd_valid_o ? w_young.addr : 5'd0;
    assign fwd_data_o  = fwd_valid_o ? w_young.data : 32'd0;
`endif
endmodule

// File: tb/tb_ex_mem_skid.sv
// Scoreboard bench for ex_mem_skid: driver pushes expected entries, negedge monitor pops on release.
`timescale 1ns/1ps
module tb_ex_mem_skid;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        ex_valid_i = 1'b0;
    logic        ex_ready_o;
    logic [4:0]  write_addr_i = '0;
    logic [31:0] write_data_i = '0;
    logic        write_reg_i = 1'b0;
    logic        overexcept_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        mem_valid_o;
    logic        mem_ready_i = 1'b0;
    logic [4:0]  write_addr_o;
    logic [31:0] write_data_o;
    logic        write_reg_o;
    logic        overexcept_o;
`ifdef EX_MEM_FORWARD_EN
    logic        fwd_valid_o;
    logic [4:0]  fwd_addr_o;
    logic [31:0] fwd_data_o;
`endif

    ex_mem_skid dut (
        .clk(clk), .resetn(resetn),
        .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
        .write_addr_i(write_addr_i), .write_data_i(write_data_i),
        .write_reg_i(write_reg_i), .overexcept_i(overexcept_i),
        .flush_i(flush_i),
        .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i),
        .write_addr_o(write_addr_o), .write_data_o(write_data_o),
        .write_reg_o(write_reg_o), .overexcept_o(overexcept_o)
`ifdef EX_MEM_FORWARD_EN
       ,.fwd_valid_o(fwd_valid_o), .fwd_addr_o(fwd_addr_o), .fwd_data_o(fwd_data_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        logic        w;
        logic        o;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;
    int rel_cnt = 0;
    int max_wait = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Release happens on the next rising edge when valid & ready and no flush.
    always @(negedge clk) begin : mon
        exp_t e;
        if (resetn && mem_valid_o && mem_ready_i && !flush_i) begin
            rel_cnt++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got addr %0d data %0h expected no output",
                         write_addr_o, write_data_o);
            end else begin
                e = sb.pop_front();
                chk("out_addr", 32'(write_addr_o), 32'(e.a));
                chk("out_data", write_data_o, e.d);
                chk("out_wreg", 32'(write_reg_o), 32'(e.w));
                chk("out_oe",   32'(overexcept_o), 32'(e.o));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ex_valid_i = 1'b0;
        flush_i    = 1'b0;
    endtask

    // Holds the entry until accepted; returns 1ns after the accepting edge with valid still high.
    task automatic send(input logic [4:0] a, input logic [31:0] d, input logic w,
                        input logic o, input logic ew);
        int waits = 0;
        ex_valid_i   = 1'b1;
        write_addr_i = a;
        write_data_i = d;
        write_reg_i  = w;
        overexcept_i = o;
        @(negedge clk);
        while (!ex_ready_o && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (waits > max_wait) max_wait = waits;
        if (!ex_ready_o) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: got ready 0 expected 1 within 50 cycles");
        end else begin
            sb.push_back('{a, d, ew, o});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1);
    end

    initial begin
        // reset state
        tick(2);
        chk("rst_ready", 32'(ex_ready_o), 32'd0);
        chk("rst_valid", 32'(mem_valid_o), 32'd0);
        chk("rst_data",  write_data_o, 32'd0);
        chk("rst_wreg",  32'(write_reg_o), 32'd0);
        resetn = 1'b1;
        tick(1);
        chk("post_rst_ready", 32'(ex_ready_o), 32'd1);
        chk("post_rst_valid", 32'(mem_valid_o), 32'd0);

        // single entry, next-cycle latency
        mem_ready_i = 1'b1;
        send(5'd5, 32'h1234_5678, 1'b1, 1'b0, 1'b1);
        idle();
        chk("lat_valid", 32'(mem_valid_o), 32'd1);
        chk("lat_addr",  32'(write_addr_o), 32'd5);
        chk("lat_data",  write_data_o, 32'h1234_5678);
        chk("lat_wreg",  32'(write_reg_o), 32'd1);
        tick(1);
        chk("lat_drain", 32'(mem_valid_o), 32'd0);

        // fill to FULL, head stable under backpressure, then drain in order
        mem_ready_i = 1'b0;
        send(5'd1, 32'hA, 1'b1, 1'b0, 1'b1);
        send(5'd2, 32'hB, 1'b1, 1'b0, 1'b1);
        idle();
        chk("full_ready", 32'(ex_ready_o), 32'd0);
        chk("full_head",  write_data_o, 32'hA);
        tick(3);
        chk("stall_head",  write_data_o, 32'hA);
        chk("stall_valid", 32'(mem_valid_o), 32'd1);
        chk("stall_ready", 32'(ex_ready_o), 32'd0);
        mem_ready_i = 1'b1;
        tick(2);
        chk("drain_valid", 32'(mem_valid_o), 32'd0);
        chk("empty_addr",  32'(write_addr_o), 32'd0);
        chk("empty_data",  write_data_o, 32'd0);
        chk("empty_ready", 32'(ex_ready_o), 32'd1);

        // write-enable sanitisation
        send(5'd3, 32'h33, 1'b1, 1'b1, 1'b0);
        send(5'd0, 32'h44, 1'b1, 1'b0, 1'b0);
        send(5'd9, 32'h99, 1'b0, 1'b0, 1'b0);
        send(5'd31, 32'hFF, 1'b1, 1'b0, 1'b1);
        idle();
        tick(2);

        // flush from FULL with a competing input and release
        mem_ready_i = 1'b0;
        send(5'd6, 32'h66, 1'b1, 1'b0, 1'b1);
        send(5'd8, 32'h88, 1'b1, 1'b0, 1'b1);
        write_addr_i = 5'd10;
        write_data_i = 32'hDEAD;
        flush_i      = 1'b1;
        mem_ready_i  = 1'b1;
        tick(1);
        chk("flush_full_valid", 32'(mem_valid_o), 32'd0);
        chk("flush_full_ready", 32'(ex_ready_o), 32'd1);
        sb.delete();
        idle();
        tick(3);
        chk("flush_full_quiet", 32'(mem_valid_o), 32'd0);

        // flush from HALF while an input would otherwise be accepted
        mem_ready_i = 1'b0;
        send(5'd11, 32'hB1, 1'b1, 1'b0, 1'b1);
        write_addr_i = 5'd12;
        write_data_i = 32'hBAD;
        flush_i      = 1'b1;
        tick(1);
        chk("flush_half_valid", 32'(mem_valid_o), 32'd0);
        sb.delete();
        idle();
        mem_ready_i = 1'b1;
        tick(3);
        chk("flush_half_quiet", 32'(mem_valid_o), 32'd0);

        // 100-cycle stream, one per cycle, never FULL
        rel_cnt  = 0;
        max_wait = 0;
        for (int i = 0; i < 100; i++)
            send(5'(i % 31 + 1), 32'(i + 32'h100), 1'b1, 1'b0, 1'b1);
        idle();
        tick(2);
        chk("stream_count", 32'(rel_cnt), 32'd100);
        chk("stream_stall", 32'(max_wait), 32'd0);
        chk("stream_sb",    32'(sb.size()), 32'd0);

`ifdef EX_MEM_FORWARD_EN
        mem_ready_i = 1'b0;
        send(5'd4, 32'h44, 1'b1, 1'b0, 1'b1);
        idle();
        chk("fwd_half_valid", 32'(fwd_valid_o), 32'd1);
        chk("fwd_half_addr",  32'(fwd_addr_o), 32'd4);
        chk("fwd_half_data",  fwd_data_o, 32'h44);
        send(5'd7, 32'h77, 1'b1, 1'b0, 1'b1);
        idle();
        chk("fwd_full_valid", 32'(fwd_valid_o), 32'd1);
        chk("fwd_full_addr",  32'(fwd_addr_o), 32'd7);
        chk("fwd_full_data",  fwd_data_o, 32'h77);
        mem_ready_i = 1'b1;
        tick(3);
        chk("fwd_empty_valid", 32'(fwd_valid_o), 32'd0);
`endif

        // asynchronous reset mid-transfer
        mem_ready_i = 1'b0;
        send(5'd13, 32'hC1, 1'b1, 1'b0, 1'b1);
        send(5'd14, 32'hC2, 1'b1, 1'b0, 1'b1);
        idle();
        #2 resetn = 1'b0;
        #1;
        chk("arst_valid", 32'(mem_valid_o), 32'd0);
        chk("arst_ready", 32'(ex_ready_o), 32'd0);
        chk("arst_data",  write_data_o, 32'd0);
        chk("arst_addr",  32'(write_addr_o), 32'd0);
        sb.delete();
        mem_ready_i = 1'b1;
        tick(2);
        resetn = 1'b1;
        tick(3);
        chk("arst_after_valid", 32'(mem_valid_o), 32'd0);
        chk("arst_after_ready", 32'(ex_ready_o), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
